// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC write sequencer.
// RTC_INIT_SEQ_EN prepends the RTC init-bit set/clear writes.
package rtc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURA,
        EMITE,
        ESPERA,
        AVANZA,
        FIN,
        FALLA
    } estado_t;

    localparam logic [7:0] INIT_ADDR = 8'h02;
    localparam logic [7:0] INIT_ON   = 8'h10;
    localparam logic [7:0] INIT_OFF  = 8'h00;

    localparam logic [7:0] BASE_ADDR_DEF = 8'h21;

`ifdef RTC_INIT_SEQ_EN
    localparam int N_INIT = 2;
`else
    localparam int N_INIT = 0;
`endif

    localparam int         N_WRITES = N_INIT + 6;
    localparam logic [2:0] LAST_IDX = 3'(N_WRITES - 1);

endpackage

// File: rtl/secuenciador_escritura_if.sv
// Handshake bundle between the write sequencer and the RTC write FSM
// plus the top-level controller status lines.
interface secuenciador_escritura_if;

    logic       inicio;
    logic       fin_escritura;
    logic       entrada;
    logic [7:0] direccion;
    logic [7:0] dato;
    logic       ocupado;
    logic       listo;
    logic       error;

    modport master (
        input  inicio,
        input  fin_escritura,
        output entrada,
        output direccion,
        output dato,
        output ocupado,
        output listo,
        output error
    );

    modport slave (
        output inicio,
        output fin_escritura,
        input  entrada,
        input  direccion,
        input  dato,
        input  ocupado,
        input  listo,
        input  error
    );

endinterface

// File: rtl/secuenciador_tabla.sv
// Index -> {direccion, dato} lookup over the time snapshot.
// With RTC_INIT_SEQ_EN the two init writes occupy index 0 and 1.
module secuenciador_tabla
    import rtc_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = BASE_ADDR_DEF
) (
    input  logic [2:0]      idx,
    input  logic [5:0][7:0] snap,
    output logic [7:0]      direccion,
    output logic [7:0]      dato
);

    logic [2:0] slot;

    always_comb begin
        slot      = idx - 3'(N_INIT);
        direccion = BASE_ADDR + {5'd0, slot};
        dato      = 8'h00;
        unique case (slot)
            3'd0: dato = snap[0];
            3'd1: dato = snap[1];
            3'd2: dato = snap[2];
            3'd3: dato = snap[3];
            3'd4: dato = snap[4];
            3'd5: dato = snap[5];
            default: begin
                direccion = 8'h00;
                dato      = 8'h00;
            end
        endcase
`ifdef RTC_INIT_SEQ_EN
        if (idx < 3'd2) begin
            direccion = INIT_ADDR;
            dato      = idx[0] ? INIT_OFF : INIT_ON;
        end
`endif
    end

endmodule

// File: rtl/secuenciador_escritura.sv
// Sequencer feeding the RTC write FSM one table entry at a time.
// Optional RTC_INIT_SEQ_EN build adds the init-bit writes up front.
module secuenciador_escritura
    import rtc_pkg::*;
#(
    parameter logic [7:0] TIMEOUT   = 8'd255,
    parameter logic [7:0] BASE_ADDR = BASE_ADDR_DEF
) (
    input logic       clk,
    input logic       reset,
    input logic [7:0] seg,
    input logic [7:0] min,
    input logic [7:0] hora,
    input logic [7:0] dia,
    input logic [7:0] mes,
    input logic [7:0] anio,
    secuenciador_escritura_if.master bus
);

    estado_t         state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      timer_q, timer_d;
    logic [5:0][7:0] snap_q, snap_d;
    logic            error_q, error_d;
    logic            entrada_q, entrada_d;
    logic            ocupado_q, ocupado_d;
    logic            listo_q, listo_d;
    logic [7:0]      dir_q, dir_d;
    logic [7:0]      dato_q, dato_d;
    logic [7:0]      tab_dir, tab_dato;

    // Looked up on next-state values so the pair is valid in EMITE itself.
    secuenciador_tabla #(
        .BASE_ADDR (BASE_ADDR)
    ) u_tabla (
        .idx       (idx_d),
        .snap      (snap_d),
        .direccion (tab_dir),
        .dato      (tab_dato)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        snap_d  = snap_q;
        error_d = error_q;
        unique case (state_q)
            IDLE: begin
                if (bus.inicio) begin
                    state_d = CAPTURA;
                    error_d = 1'b0;
                end
            end
            CAPTURA: begin
                snap_d  = {anio, mes, dia, hora, min, seg};
                idx_d   = 3'd0;
                state_d = EMITE;
            end
            EMITE: begin
                timer_d = 8'd0;
                state_d = ESPERA;
            end
            ESPERA: begin
                timer_d = timer_q + 8'd1;
                if (bus.fin_escritura) begin
                    state_d = AVANZA;
                end else if (timer_d == TIMEOUT) begin
                    state_d = FALLA;
                    error_d = 1'b1;
                end
            end
            AVANZA: begin
                if (idx_q == LAST_IDX) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = EMITE;
                end
            end
            FIN:     state_d = IDLE;
            FALLA:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        entrada_d = (state_d == EMITE);
        listo_d   = (state_d == FIN);
        ocupado_d = !(state_d inside {IDLE, FIN, FALLA});
        dir_d     = (state_d == EMITE) ? tab_dir  : dir_q;
        dato_d    = (state_d == EMITE) ? tab_dato : dato_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            timer_q   <= 8'd0;
            snap_q    <= '0;
            error_q   <= 1'b0;
            entrada_q <= 1'b0;
            ocupado_q <= 1'b0;
            listo_q   <= 1'b0;
            dir_q     <= 8'h00;
            dato_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            snap_q    <= snap_d;
            error_q   <= error_d;
            entrada_q <= entrada_d;
            ocupado_q <= ocupado_d;
            listo_q   <= listo_d;
            dir_q     <= dir_d;
            dato_q    <= dato_d;
        end
    end

    assign bus.entrada   = entrada_q;
    assign bus.direccion = dir_q;
    assign bus.dato      = dato_q;
    assign bus.ocupado   = ocupado_q;
    assign bus.listo     = listo_q;
    assign bus.error     = error_q;

endmodule
